// File: rtl/imm_pkg.sv
// Shared format codes and opcode constants for the decode-stage immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Fetch-side and regfile-side valid/ready handshake of the immediate generator stage.
interface imm_gen_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target, out_pc, out_illegal
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational format decode and sign-extended immediate extraction.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]             instr,
    output fmt_e                    fmt,
    output logic signed [XLEN-1:0]  imm,
    output logic                    illegal
);
    logic signed [31:0] imm32;

    always_comb begin
        fmt     = FMT_NONE;
        imm32   = '0;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_OPIMM32: begin
                // Word-sized ALU ops only exist on RV64.
                if (XLEN == 64) begin
                    fmt   = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: illegal = 1'b1;
        endcase
    end

    assign imm = XLEN'(imm32);
endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator: decode, pc+imm target, 2-entry skid buffer, illegal counter.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    imm_gen_stage_if.slave    bus,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  illegal_cnt
);
    fmt_e                   fmt_p0;
    logic signed [XLEN-1:0] imm_p0;
    logic signed [XLEN-1:0] pc_p0;
    logic signed [XLEN-1:0] tgt_p0;
    logic                   ill_p0;

    logic                   vld_p1;
    fmt_e                   fmt_p1;
    logic signed [XLEN-1:0] imm_p1, tgt_p1, pc_p1;
    logic                   ill_p1;

    logic                   skid_full;
    fmt_e                   fmt_sk;
    logic signed [XLEN-1:0] imm_sk, tgt_sk, pc_sk;
    logic                   ill_sk;

    logic accept;
    logic main_free;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Stage p0: combinational decode and target adder on the incoming word.
    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (bus.in_instr),
        .fmt     (fmt_p0),
        .imm     (imm_p0),
        .illegal (ill_p0)
    );

    assign pc_p0     = bus.in_pc;
    assign tgt_p0    = pc_p0 + imm_p0;
    assign bus.in_ready = !skid_full && !rst;
    assign accept    = bus.in_valid && bus.in_ready;
    assign main_free = !vld_p1 || bus.out_ready;

    // Stage p1: main output register backed by a single skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            fmt_p1    <= FMT_NONE;
            imm_p1    <= '0;
            tgt_p1    <= '0;
            pc_p1     <= '0;
            ill_p1    <= 1'b0;
            skid_full <= 1'b0;
            fmt_sk    <= FMT_NONE;
            imm_sk    <= '0;
            tgt_sk    <= '0;
            pc_sk     <= '0;
            ill_sk    <= 1'b0;
        end else if (main_free) begin
            if (skid_full) begin
                vld_p1    <= 1'b1;
                fmt_p1    <= fmt_sk;
                imm_p1    <= imm_sk;
                tgt_p1    <= tgt_sk;
                pc_p1     <= pc_sk;
                ill_p1    <= ill_sk;
                skid_full <= 1'b0;
            end else if (accept) begin
                vld_p1 <= 1'b1;
                fmt_p1 <= fmt_p0;
                imm_p1 <= imm_p0;
                tgt_p1 <= tgt_p0;
                pc_p1  <= pc_p0;
                ill_p1 <= ill_p0;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (accept) begin
            skid_full <= 1'b1;
            fmt_sk    <= fmt_p0;
            imm_sk    <= imm_p0;
            tgt_sk    <= tgt_p0;
            pc_sk     <= pc_p0;
            ill_sk    <= ill_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            illegal_cnt <= '0;
        end else if (accept && ill_p0) begin
            illegal_cnt <= sat_inc(illegal_cnt);
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.out_fmt     = fmt_p1;
    assign bus.out_imm     = imm_p1;
    assign bus.out_target  = tgt_p1;
    assign bus.out_pc      = pc_p1;
    assign bus.out_illegal = ill_p1;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: scoreboarded XLEN=32 instance plus an XLEN=64 / CNT_W=2 instance.
module tb_imm_gen_stage;
    logic clk;
    logic rst;
    logic clr32, clr64;
    logic [15:0] cnt32;
    logic [1:0]  cnt64;

    imm_gen_stage_if #(.XLEN(32)) i32 ();
    imm_gen_stage_if #(.XLEN(64)) i64 ();

    imm_gen_stage #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .bus(i32), .cnt_clr(clr32), .illegal_cnt(cnt32));
    imm_gen_stage #(.XLEN(64), .CNT_W(2)) dut64 (
        .clk(clk), .rst(rst), .bus(i64), .cnt_clr(clr64), .illegal_cnt(cnt64));

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [63:0] pc;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int occ      = 0;
    bit stall    = 0;
    logic [127:0] held;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // Reference decode written directly from the RISC-V immediate layouts.
    function automatic exp_t model(logic [31:0] ins, logic [63:0] pc, bit x64);
        exp_t e;
        e.ill = 1'b0;
        e.fmt = 3'd7;
        e.imm = '0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin e.fmt = 3'd0; e.imm = {{52{ins[31]}}, ins[31:20]}; end
            7'h1B: begin
                if (x64) begin e.fmt = 3'd0; e.imm = {{52{ins[31]}}, ins[31:20]}; end
                else e.ill = 1'b1;
            end
            7'h23: begin e.fmt = 3'd1; e.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]}; end
            7'h63: begin e.fmt = 3'd2;
                e.imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
            7'h37, 7'h17: begin e.fmt = 3'd3; e.imm = {{32{ins[31]}}, ins[31:12], 12'b0}; end
            7'h6F: begin e.fmt = 3'd4;
                e.imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
            default: e.ill = 1'b1;
        endcase
        e.pc  = pc;
        e.tgt = pc + e.imm;
        if (!x64) begin
            e.imm = {32'b0, e.imm[31:0]};
            e.tgt = {32'b0, e.tgt[31:0]};
            e.pc  = {32'b0, e.pc[31:0]};
        end
        return e;
    endfunction

    // Output-side scoreboard and occupancy model for the 32-bit instance.
    always @(negedge clk) begin
        logic [127:0] payload;
        exp_t e;
        payload = {28'b0, i32.out_imm, i32.out_pc, i32.out_target, i32.out_fmt, i32.out_illegal};
        if (rst) begin
            chk("in_ready_in_reset", i32.in_ready, 1'b0);
            q.delete();
            occ   = 0;
            stall = 0;
        end else begin
            chk("in_ready_vs_occupancy", i32.in_ready, occ < 2);
            chk("out_valid_vs_occupancy", i32.out_valid, occ > 0);
            if (stall) chk("stall_payload_stable", payload, held);
            if (i32.out_valid && i32.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", i32.out_valid, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("out_imm", i32.out_imm, e.imm);
                    chk("out_target", i32.out_target, e.tgt);
                    chk("out_pc", i32.out_pc, e.pc);
                    chk("out_fmt", i32.out_fmt, e.fmt);
                    chk("out_illegal", i32.out_illegal, e.ill);
                end
            end
            stall = i32.out_valid && !i32.out_ready;
            held  = payload;
            if (i32.in_valid && i32.in_ready)
                q.push_back(model(i32.in_instr, {32'b0, i32.in_pc}, 1'b0));
            occ = occ + ((i32.in_valid && i32.in_ready) ? 1 : 0)
                      - ((i32.out_valid && i32.out_ready) ? 1 : 0);
        end
    end

    task automatic send32(input logic [31:0] ins, input logic [31:0] pc);
        int t = 0;
        i32.in_valid = 1'b1;
        i32.in_instr = ins;
        i32.in_pc    = pc;
        @(negedge clk);
        while (!i32.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!i32.in_ready) chk("accept_timeout32", i32.in_ready, 1'b1);
        @(posedge clk);
        #1;
        i32.in_valid = 1'b0;
    endtask

    task automatic send64(input logic [31:0] ins, input logic [63:0] pc);
        int t = 0;
        i64.in_valid = 1'b1;
        i64.in_instr = ins;
        i64.in_pc    = pc;
        @(negedge clk);
        while (!i64.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!i64.in_ready) chk("accept_timeout64", i64.in_ready, 1'b1);
        @(posedge clk);
        #1;
        i64.in_valid = 1'b0;
    endtask

    task automatic drain32();
        int t = 0;
        i32.out_ready = 1'b1;
        while ((q.size() != 0 || i32.out_valid) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] stream_ins [8];
        bit          pat [6];
        exp_t        e;
        stream_ins = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h001000EF,
                       32'h123452B7, 32'h00001097, 32'h0000001B, 32'h80000FE3};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        clr32 = 1'b0; clr64 = 1'b0;
        i32.in_valid = 1'b0; i32.in_instr = '0; i32.in_pc = '0; i32.out_ready = 1'b1;
        i64.in_valid = 1'b0; i64.in_instr = '0; i64.in_pc = '0; i64.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", i32.in_ready, 1'b1);
        chk("rst_out_valid", i32.out_valid, 1'b0);
        chk("rst_out_imm", i32.out_imm, 32'h0);
        chk("rst_out_target", i32.out_target, 32'h0);
        chk("rst_out_pc", i32.out_pc, 32'h0);
        chk("rst_out_fmt", i32.out_fmt, 3'd7);
        chk("rst_out_illegal", i32.out_illegal, 1'b0);
        chk("rst_illegal_cnt", cnt32, 16'h0);
        chk("rst_illegal_cnt64", cnt64, 2'h0);
        next_cycle();

        send32(32'hFFF00093, 32'h0);
        @(negedge clk);
        chk("addi_latency_valid", i32.out_valid, 1'b1);
        chk("addi_imm", i32.out_imm, 32'hFFFFFFFF);
        chk("addi_target", i32.out_target, 32'hFFFFFFFF);
        next_cycle();
        send32(32'hFE112E23, 32'h4);
        send32(32'hFE000CE3, 32'h100);
        @(negedge clk);
        chk("beq_target", i32.out_target, 32'h000000F8);
        next_cycle();
        send32(32'h001000EF, 32'h1000);
        @(negedge clk);
        chk("jal_target", i32.out_target, 32'h1800);
        next_cycle();
        send32(32'h123452B7, 32'h2000);
        drain32();

        send32(32'h00000000, 32'h10);
        send32(32'h0000001B, 32'h14);
        @(negedge clk);
        chk("illegal_fmt", i32.out_fmt, 3'd7);
        chk("illegal_cnt_two", cnt32, 16'd2);
        next_cycle();
        clr32 = 1'b1;
        send32(32'h00000007, 32'h18);
        clr32 = 1'b0;
        @(negedge clk);
        chk("illegal_cnt_clear_wins", cnt32, 16'd0);
        next_cycle();
        send32(32'h00000002, 32'h1C);
        @(negedge clk);
        chk("illegal_cnt_after_clear", cnt32, 16'd1);
        next_cycle();
        drain32();

        fork
            begin
                for (int i = 0; i < 8; i++) send32(stream_ins[i], 32'h200 + 32'(i * 4));
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    i32.out_ready = pat[k % 6];
                    next_cycle();
                end
            end
        join
        drain32();

        i32.out_ready = 1'b0;
        send32(32'h00500093, 32'h300);
        send32(32'h00600093, 32'h304);
        @(negedge clk);
        chk("skid_full_in_ready", i32.in_ready, 1'b0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_ready_low", i32.in_ready, 1'b0);
        next_cycle();
        rst = 1'b0;
        i32.out_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_out_valid", i32.out_valid, 1'b0);
        chk("post_reset_in_ready", i32.in_ready, 1'b1);
        repeat (3) next_cycle();
        chk("post_reset_no_stale", i32.out_valid, 1'b0);

        send64(32'h800002B7, 64'h0);
        @(negedge clk);
        chk("lui64_valid", i64.out_valid, 1'b1);
        chk("lui64_imm", i64.out_imm, 64'hFFFFFFFF80000000);
        chk("lui64_fmt", i64.out_fmt, 3'd3);
        next_cycle();
        send64(32'h0010009B, 64'h10);
        @(negedge clk);
        e = model(32'h0010009B, 64'h10, 1'b1);
        chk("addiw64_imm", i64.out_imm, e.imm);
        chk("addiw64_target", i64.out_target, e.tgt);
        chk("addiw64_illegal", i64.out_illegal, 1'b0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            send64(32'h00000000, 64'(i));
            if (i == 2) begin
                @(negedge clk);
                chk("cnt64_three", cnt64, 2'd3);
                next_cycle();
            end
        end
        @(negedge clk);
        chk("cnt64_saturated", cnt64, 2'd3);
        chk("illegal64_fmt", i64.out_fmt, 3'd7);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered immediate generator for the decode stage. Decodes the instruction format from the opcode and sign-extends the immediate to XLEN. Computes the PC-relative target pc+imm and flags unsupported opcodes. Sits between fetch and the register-file read, decoupled on both sides by a valid/ready 2-entry skid buffer.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction word
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  output payload valid
out_ready  in  1  downstream accepts this cycle
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  format code: I=0, S=1, B=2, U=3, J=4, NONE=7
out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
out_pc  out  XLEN  PC carried with the payload
out_illegal  out  1  opcode not supported
cnt_clr  in  1  clear illegal_cnt
illegal_cnt  out  CNT_W  accepted illegal instructions, saturating

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, skid entry empty, illegal_cnt=0.
  - out_imm, out_target, out_pc = 0; out_fmt=NONE; out_illegal=0.
  - in_ready=0 while rst=1; in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-transfer discards both buffered entries. No partial output.
- Format decode (combinational, before the register) on opcode=in_instr[6:0]:
  - I: 0000011, 0010011, 1100111, 1110011. Also 0011011 when XLEN=64.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - Any other opcode, including instr[1:0]!=11 and 0011011 when XLEN=32: fmt=NONE, imm=0, illegal=1.
- Immediate construction (bit 31 is the sign bit, replicated up to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
- Target:
  - target = pc + imm, computed for every format, truncated to XLEN bits (wraps).
  - Meaningful only for B, J and AUIPC. Consumers ignore it otherwise.
- Handshake: transfer on valid&&ready at each port.
  - out_valid high with out_ready low holds all out_* stable until accepted.
  - in_valid may deassert freely; in_instr is sampled only on transfer.
- Skid buffer: main output register plus one skid register. in_ready = !skid_full, registered.
  - Accept, output empty or being drained: data goes to main. Latency 1 cycle; throughput 1/cycle.
  - Accept while main is held (out_valid && !out_ready): data goes to skid, and in_ready drops next cycle.
  - Main accepted while skid full: skid moves to main, and in_ready rises next cycle.
  - Order is strictly preserved. No loss or duplication under any out_ready pattern.
- illegal_cnt:
  - +1 per accepted instruction with illegal=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 sets it to 0; clear wins over a same-cycle increment.

Decomposition:
- Package imm_pkg holds:
  - format codes FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE (3-bit);
  - opcode constants OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL.
- Sub-module imm_decode (combinational, parametrised by XLEN): instr → {fmt, imm, illegal}.
- imm_gen_stage instantiates imm_decode and owns the target adder, the skid buffer and the counter.

Test Plan:
- XLEN=32, ADDI 0xFFF00093, pc=0 → one cycle later out_valid=1, fmt=I, imm=0xFFFFFFFF, target=0xFFFFFFFF.
- SW 0xFE112E23 → fmt=S, imm=0xFFFFFFFC. BEQ 0xFE000CE3 with pc=0x100 → fmt=B, imm=0xFFFFFFF8, target=0x000000F8.
- JAL 0x001000EF with pc=0x1000 → fmt=J, imm=0x800, target=0x1800. LUI 0x123452B7 → fmt=U, imm=0x12345000. XLEN=64: LUI 0x800002B7 → imm=0xFFFFFFFF80000000.
- Input 0x00000000, then 0x0000001B with XLEN=32 → both illegal=1, fmt=NONE, illegal_cnt=2. cnt_clr together with a third illegal accept → illegal_cnt=0.
- Back-to-back stream of 8 instructions with out_ready toggling 1,0,0,1,0,1…:
  - outputs arrive in order with no drops;
  - in_ready=0 only while skid is full;
  - payload stays stable while stalled.
- Skid full, then rst=1 for one cycle → out_valid=0 and in_ready=0 during reset, in_ready=1 next cycle, no stale output. CNT_W=2 with 5 illegal accepts → illegal_cnt saturates at 3.
